// File: rtl/rc6_serial_tx.sv
// Serial transmitter for the 128-bit RC6 result word on the clk_out / sta_out / data_put link.
// A word is framed by sta_out and sent MSB first, one bit per generated clk_out period.
module rc6_serial_tx #(
    parameter int DATA_W  = 128,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data_back,
    output logic              busy,
    output logic              done,
    output logic              clk_out,
    output logic              sta_out,
    output logic              data_put
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("rc6_serial_tx: CLK_DIV must be >= 1");
    end

    logic [1:0]        state;
    // The current bit lives in data_put, so only the bits still to be sent are held here.
    logic [DATA_W-2:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            clk_out  <= 1'b0;
            sta_out  <= 1'b0;
            data_put <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= data_back[DATA_W-2:0];
                        data_put <= data_back[DATA_W-1];
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        busy     <= 1'b1;
                        sta_out  <= 1'b1;
                        clk_out  <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!clk_out) begin
                            clk_out <= 1'b1;
                        end else if (bit_cnt != LAST_BIT) begin
                            // Data moves only here, a full low phase ahead of the next rising edge.
                            data_put <= shreg[DATA_W-2];
                            shreg    <= {shreg[DATA_W-3:0], 1'b0};
                            bit_cnt  <= bit_cnt + 1'b1;
                            clk_out  <= 1'b0;
                        end else begin
                            data_put <= 1'b0;
                            sta_out  <= 1'b0;
                            clk_out  <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    sta_out  <= 1'b0;
                    clk_out  <= 1'b0;
                    data_put <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rc6_serial_tx.md
Name: rc6_serial_tx

Overview:
- Serial frame transmitter that sends the 128-bit RC6 result word (`data_back`) off-chip on the `clk_out` / `sta_out` / `data_put` pins.
- It is the transmit end of the same 3-wire serial link whose receive end (`clk_in` / `sta_in` / `data_in`) feeds 128-bit words into the RC6 core.
- The block captures a word on a load strobe, shifts it out MSB-first with a generated bit clock, frames it with `sta_out`, and pulses `done` when finished.

Parameters:
- DATA_W, 128, frame width in bits. Bit counter width is $clog2(DATA_W).
- CLK_DIV, 2, number of `clk` cycles per `clk_out` half-period. Must be ≥ 1; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  request to transmit; sampled only in IDLE.
- data_back  input  DATA_W  word to send; captured on the accepted load cycle.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last bit period ends.
- clk_out  output  1  generated bit clock; idles low.
- sta_out  output  1  frame-valid; high for exactly the DATA_W bit periods.
- data_put  output  1  serial data; MSB (bit DATA_W-1) first.

Behaviour:
- Clock is `clk`; reset is `reset`, asynchronous and active-high. While `reset` is high:
  - state = IDLE;
  - `busy`, `done`, `clk_out`, `sta_out`, `data_put` = 0;
  - shift register, bit counter and divider counter = 0.
- Reset mid-frame: all outputs drop to 0 asynchronously. The frame is abandoned, not resumed. The first edge after reset release is in IDLE.
- State machine: IDLE, SEND, DONE.
- IDLE:
  - `load` = 1 at a rising edge: shift register <= `data_back`, bit counter <= 0, divider <= 0, go to SEND.
  - `load` = 0: stay in IDLE.
- SEND entry (first cycle after the accepting edge): `sta_out` = 1, `clk_out` = 0, `data_put` = shift register MSB.
- SEND, each bit period = 2*CLK_DIV `clk` cycles:
  - Low phase: `clk_out` = 0 for CLK_DIV cycles.
  - High phase: `clk_out` = 1 for CLK_DIV cycles.
  - `data_put` changes only at the start of a low phase. It is stable across the rising edge of `clk_out`, which is where the receiver samples.
- End of a high phase with bit counter < DATA_W-1: shift register left by 1 (zero fill), bit counter +1, start the next low phase.
- End of a high phase with bit counter = DATA_W-1: go to DONE.
- DONE, for exactly one cycle:
  - `done` = 1, `busy` = 1;
  - `sta_out`, `clk_out`, `data_put` = 0;
  - then go to IDLE.
- Timing, with `load` accepted at edge 0:
  - `sta_out` high from cycle 1 through cycle DATA_W*2*CLK_DIV inclusive.
  - `done` high in cycle DATA_W*2*CLK_DIV + 1.
  - Earliest next accept is at the edge ending the first IDLE cycle, giving a minimum inter-frame `sta_out` low gap of 2 cycles.
- `load` while `busy` = 1: ignored, with no queuing and no corruption. Changes to `data_back` after capture have no effect.
- `load` held high continuously: frames back-to-back, separated by the 2-cycle gap.
- Exactly DATA_W rising edges of `clk_out` occur per frame. There are no `clk_out` edges outside SEND.
- CLK_DIV = 1: `clk_out` toggles every cycle during SEND; all rules above still hold.
- All outputs are driven directly from registers; no combinational paths from inputs to outputs.

Test Plan:
- Single frame: reset, CLK_DIV = 2, `load` for 1 cycle with `data_back` = 128'h8000_0000_0000_0000_0000_0000_0000_0001.
  - `sta_out` high for exactly 512 cycles.
  - Receiver model sampling on `clk_out` rise reconstructs the word; first bit 1, bits 2-127 = 0, last bit 1.
  - `done` pulses once at cycle 513.
- Pattern and edge count: `data_back` = {32{4'hA}}.
  - `data_put` alternates 1,0,… starting with 1.
  - Exactly 128 `clk_out` rising edges, each with `data_put` stable one cycle before and after.
- Load while busy: second `load` with 128'hDEAD_BEEF_… at bit 50.
  - No effect; the first word completes intact.
  - `data_back` toggling during the frame is also ignored.
- Back-to-back: `load` held high with two different words.
  - Two frames, `sta_out` low for exactly 2 cycles between them.
  - Both words reconstructed.
- Reset mid-frame: assert `reset` at bit 40.
  - All outputs 0 in the same cycle (asynchronously).
  - After release with `load` = 0, outputs stay 0.
  - A new load sends a full, correct 128-bit frame.
- CLK_DIV = 1 variant with random words: `sta_out` high 256 cycles, `done` at cycle 257, words match.
